// File: rtl/sdram_pkg.sv
// sdram_pkg: command encodings, controller state set and timing defaults shared
// by the SDRAM init/refresh controller and its cycle timer.
package sdram_pkg;

   // {cs_n, ras_n, cas_n, we_n}
   typedef enum logic [3:0] {
      CMD_NOP  = 4'b0111,
      CMD_PRE  = 4'b0010,
      CMD_AREF = 4'b0001,
      CMD_LMR  = 4'b0000
   } sdr_cmd_e;

   typedef enum logic [3:0] {
      S_PWR,
      S_PRE,
      S_WAIT_RP,
      S_AREF,
      S_WAIT_RFC,
      S_LMR,
      S_WAIT_MRD,
      S_IDLE,
      S_REF,
      S_REF_WAIT
   } sdr_state_e;

   localparam int unsigned T_INIT_CYC_DEF = 20000;
   localparam int unsigned T_RP_DEF       = 2;
   localparam int unsigned T_RFC_DEF      = 7;
   localparam int unsigned T_MRD_DEF      = 2;
   localparam int unsigned T_REFI_DEF     = 780;
   localparam int unsigned INIT_REF_DEF   = 2;
   localparam logic [12:0] MODE_REG_DEF   = 13'h033;

   // A10 high selects all banks for PRECHARGE
   localparam logic [12:0] ADDR_PRE_ALL   = 13'h0400;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sdr_cyc_timer.sv
// sdr_cyc_timer: loadable down-counter shared by every timed wait state.
// start_i loads load_i; the count then decrements to zero and holds there.
module sdr_cyc_timer #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic [W-1:0] load_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // next count: load has priority, otherwise count down and stick at zero
   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = load_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // count register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sdram_init_refresh_ctrl.sv
// sdram_init_refresh_ctrl: SDRAM power-up init sequencer and auto-refresh scheduler.
// Optional feature macro SDR_REF_POSTPONE_EN: refresh debt counter up to 8 owed
// refreshes instead of a single pending flag.
//
// state      | meaning
// S_PWR      | power-up stable wait, NOP
// S_PRE      | PRECHARGE ALL (A10=1)
// S_WAIT_RP  | tRP NOPs
// S_AREF     | init AUTO REFRESH
// S_WAIT_RFC | tRFC NOPs, loop back until INIT_REF issued
// S_LMR      | LOAD MODE REGISTER
// S_WAIT_MRD | tMRD NOPs
// S_IDLE     | bus yielded to main engine, waiting for refresh grant
// S_REF      | runtime AUTO REFRESH
// S_REF_WAIT | tRFC NOPs, ref_done on the last one
module sdram_init_refresh_ctrl
   import sdram_pkg::*;
#(
   parameter int unsigned T_INIT_CYC = T_INIT_CYC_DEF,
   parameter int unsigned T_RP       = T_RP_DEF,
   parameter int unsigned T_RFC      = T_RFC_DEF,
   parameter int unsigned T_MRD      = T_MRD_DEF,
   parameter int unsigned T_REFI     = T_REFI_DEF,
   parameter int unsigned INIT_REF   = INIT_REF_DEF,
   parameter logic [12:0] MODE_REG   = MODE_REG_DEF
) (
   input  logic        sdram_clk,
   input  logic        RESETN,
   input  logic        ref_gnt,
   output logic        cmd_own,
   output logic        sdr_cs_n,
   output logic        sdr_ras_n,
   output logic        sdr_cas_n,
   output logic        sdr_we_n,
   output logic [1:0]  sdr_ba,
   output logic [12:0] sdr_addr,
   output logic        init_done,
   output logic        ref_req,
   output logic        ref_done,
   output logic        ref_overrun
);

   localparam int unsigned TMR_W  = $clog2(max2(max2(T_INIT_CYC, T_RFC), max2(T_RP, T_MRD))) + 1;
   localparam int unsigned IVL_W  = $clog2(T_REFI);
   localparam int unsigned IREF_W = $clog2(INIT_REF + 1);

`ifdef SDR_REF_POSTPONE_EN
   localparam int unsigned OWED_W = 4;
   localparam logic [OWED_W-1:0] OWED_MAX = 4'd8;
`else
   localparam int unsigned OWED_W = 1;
   localparam logic [OWED_W-1:0] OWED_MAX = 1'b1;
`endif

   sdr_state_e        state_q, state_d;
   sdr_cmd_e          cmd;
   logic              tmr_start;
   logic [TMR_W-1:0]  tmr_load;
   logic              tmr_zero;
   logic              pwr_arm_q;
   logic [IREF_W-1:0] init_ref_q;
   logic [IVL_W-1:0]  ivl_q, ivl_d;
   logic [OWED_W-1:0] owed_q, owed_d;
   logic              ovr_q, ovr_d;
   logic              ivl_wrap;
   logic              aref_issue;

   // Wait-state timer. Each wait lasts T-1 cycles after its command, so the
   // commanding state loads T-2 and the wait exits on the zero flag.
   sdr_cyc_timer #(.W(TMR_W)) u_timer (
      .clk_i   (sdram_clk),
      .rst_ni  (RESETN),
      .start_i (tmr_start),
      .load_i  (tmr_load),
      .zero_o  (tmr_zero)
   );

   // state register
   always_ff @(posedge sdram_clk or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= S_PWR;
      end else begin
         state_q <= state_d;
      end
   end

   // next state and timer loads
   always_comb begin
      state_d   = state_q;
      tmr_start = 1'b0;
      tmr_load  = '0;
      case (state_q)
         S_PWR: begin
            // first S_PWR cycle arms the timer so the wait totals T_INIT_CYC cycles
            if (!pwr_arm_q) begin
               tmr_start = 1'b1;
               tmr_load  = TMR_W'(T_INIT_CYC - 2);
            end else if (tmr_zero) begin
               state_d = S_PRE;
            end
         end
         S_PRE: begin
            state_d   = S_WAIT_RP;
            tmr_start = 1'b1;
            tmr_load  = TMR_W'(T_RP - 2);
         end
         S_WAIT_RP:  if (tmr_zero) state_d = S_AREF;
         S_AREF: begin
            state_d   = S_WAIT_RFC;
            tmr_start = 1'b1;
            tmr_load  = TMR_W'(T_RFC - 2);
         end
         S_WAIT_RFC: begin
            if (tmr_zero) begin
               state_d = (init_ref_q == IREF_W'(INIT_REF)) ? S_LMR : S_AREF;
            end
         end
         S_LMR: begin
            state_d   = S_WAIT_MRD;
            tmr_start = 1'b1;
            tmr_load  = TMR_W'(T_MRD - 2);
         end
         S_WAIT_MRD: if (tmr_zero) state_d = S_IDLE;
         S_IDLE:     if (ref_req && ref_gnt) state_d = S_REF;
         S_REF: begin
            state_d   = S_REF_WAIT;
            tmr_start = 1'b1;
            tmr_load  = TMR_W'(T_RFC - 2);
         end
         S_REF_WAIT: if (tmr_zero) state_d = S_IDLE;
         default:    state_d = S_PWR;
      endcase
   end

   // command bus drive per state
   always_comb begin
      cmd      = CMD_NOP;
      cmd_own  = 1'b1;
      sdr_addr = '0;
      case (state_q)
         S_PRE: begin
            cmd      = CMD_PRE;
            sdr_addr = ADDR_PRE_ALL;
         end
         S_AREF, S_REF: cmd = CMD_AREF;
         S_LMR: begin
            cmd      = CMD_LMR;
            sdr_addr = MODE_REG;
         end
         S_IDLE:  cmd_own = 1'b0;
         default: ;
      endcase
   end

   assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd;
   assign sdr_ba    = 2'b00;
   assign init_done = (state_q == S_IDLE) || (state_q == S_REF) || (state_q == S_REF_WAIT);
   assign ref_done  = (state_q == S_REF_WAIT) && tmr_zero;

   // init bookkeeping: power-up arm flag and count of init refreshes issued
   always_ff @(posedge sdram_clk or negedge RESETN) begin
      if (!RESETN) begin
         pwr_arm_q  <= 1'b0;
         init_ref_q <= '0;
      end else begin
         if (state_q == S_PWR) pwr_arm_q <= 1'b1;
         if (state_q == S_AREF) init_ref_q <= init_ref_q + 1'b1;
      end
   end

   assign ivl_wrap   = init_done && (ivl_q == IVL_W'(T_REFI - 1));
   assign aref_issue = (state_q == S_REF);

   // interval counter and refresh debt; a wrap coincident with an issue cancels out
   always_comb begin
      ivl_d  = '0;
      owed_d = owed_q;
      ovr_d  = ovr_q;
      if (init_done) begin
         ivl_d = ivl_wrap ? '0 : ivl_q + 1'b1;
      end
      if (ivl_wrap && !aref_issue) begin
         if (owed_q == OWED_MAX) begin
            ovr_d = 1'b1;
         end else begin
            owed_d = owed_q + 1'b1;
         end
      end else if (!ivl_wrap && aref_issue) begin
         owed_d = owed_q - 1'b1;
      end
   end

   // interval / debt registers
   always_ff @(posedge sdram_clk or negedge RESETN) begin
      if (!RESETN) begin
         ivl_q  <= '0;
         owed_q <= '0;
         ovr_q  <= 1'b0;
      end else begin
         ivl_q  <= ivl_d;
         owed_q <= owed_d;
         ovr_q  <= ovr_d;
      end
   end

   assign ref_req     = (owed_q != '0);
   assign ref_overrun = ovr_q;

endmodule

// File: tb/tb_sdram_init_refresh_ctrl.sv
// Bench for sdram_init_refresh_ctrl with short init and refresh interval.
// A timeline model predicts every output each cycle; directed literal checks pin
// the key event times of that model.
module tb_sdram_init_refresh_ctrl;

   localparam int TI    = 20;
   localparam int TRP   = 2;
   localparam int TRFC  = 7;
   localparam int TMRD  = 2;
   localparam int TREFI = 50;
   localparam int IREF  = 2;
   localparam logic [12:0] MODE = 13'h033;
`ifdef SDR_REF_POSTPONE_EN
   localparam int OWE_MAX = 8;
`else
   localparam int OWE_MAX = 1;
`endif
   localparam int T_LMR  = TI + TRP + IREF * TRFC;
   localparam int T_IDLE = T_LMR + TMRD;
   localparam logic [23:0] RST_V = {1'b1, 4'b0111, 2'b00, 13'h0, 4'b0000};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        gnt = 1'b0;
   logic        cmd_own, cs_n, ras_n, cas_n, we_n;
   logic [1:0]  ba;
   logic [12:0] addr;
   logic        init_done, ref_req, ref_done, ref_overrun;
   logic [3:0]  cmd4;
   logic [23:0] obs;

   int t = 0;
   int owed = 0;
   int rfc = 0;
   int ovr = 0;
   int npass = 0;
   int ntot = 0;

   always #5 clk = ~clk;

   sdram_init_refresh_ctrl #(
      .T_INIT_CYC (TI),
      .T_RP       (TRP),
      .T_RFC      (TRFC),
      .T_MRD      (TMRD),
      .T_REFI     (TREFI),
      .INIT_REF   (IREF),
      .MODE_REG   (MODE)
   ) dut (
      .sdram_clk   (clk),
      .RESETN      (rst_n),
      .ref_gnt     (gnt),
      .cmd_own     (cmd_own),
      .sdr_cs_n    (cs_n),
      .sdr_ras_n   (ras_n),
      .sdr_cas_n   (cas_n),
      .sdr_we_n    (we_n),
      .sdr_ba      (ba),
      .sdr_addr    (addr),
      .init_done   (init_done),
      .ref_req     (ref_req),
      .ref_done    (ref_done),
      .ref_overrun (ref_overrun)
   );

   assign cmd4 = {cs_n, ras_n, cas_n, we_n};
   assign obs  = {cmd_own, cmd4, ba, addr, init_done, ref_req, ref_done, ref_overrun};

   task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] req);
      ntot++;
      if (act === req) npass++;
      else $display("FAIL %s: got %h, required %h (t=%0d)", nm, act, req, t);
   endtask

   // Cycle model: init commands are fixed offsets from reset release; at run time
   // a refresh occupies a TRFC-cycle window and debt moves with interval expiries.
   always @(negedge clk) begin : model_chk
      logic [3:0]  c;
      logic [12:0] a;
      logic        own, id, rq, dn, ov, wrap, issue;
      if (!rst_n) begin
         t = 0; owed = 0; rfc = 0; ovr = 0;
         chk("reset_hold", obs, RST_V);
      end else begin
         c = 4'b0111; a = '0; own = 1'b1; id = 1'b0; rq = 1'b0; dn = 1'b0; ov = 1'b0;
         if (t < T_IDLE) begin
            if (t == TI) begin
               c = 4'b0010; a = 13'h0400;
            end else if (t == T_LMR) begin
               c = 4'b0000; a = MODE;
            end else if (t >= TI + TRP && t < T_LMR && (t - TI - TRP) % TRFC == 0) begin
               c = 4'b0001;
            end
         end else begin
            id    = 1'b1;
            rq    = (owed > 0);
            ov    = (ovr != 0);
            issue = (rfc == TRFC);
            if (issue) c = 4'b0001;
            own   = (rfc != 0);
            dn    = (rfc == 1);
            wrap  = ((t - T_IDLE) % TREFI) == TREFI - 1;
            if (wrap && !issue) begin
               if (owed == OWE_MAX) ovr = 1;
               else owed++;
            end else if (!wrap && issue) begin
               owed--;
            end
            if (rfc > 0) rfc--;
            else if (rq && gnt) rfc = TRFC;
         end
         chk("cycle", obs, {own, c, 2'b00, a, id, rq, dn, ov});
         t++;
      end
   end

   task automatic wait_t(input int p);
      int n = 0;
      do begin
         @(posedge clk); #2; n++;
      end while (t != p && n < 3000);
      if (t != p) begin
         ntot++;
         $display("FAIL wait_t: reached t=%0d, required %0d", t, p);
      end
   endtask

   task automatic release_rst();
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic async_reset(input string nm);
      rst_n = 1'b0;
      #1 chk(nm, obs, RST_V);
      repeat (3) @(posedge clk);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 chk("rst_vals", obs, RST_V);
      release_rst();

      // reset during init S_WAIT_RFC (first AREF at 22)
      wait_t(24); async_reset("async_rst_init");
      gnt = 1'b1;
      release_rst();

      // init sequence
      wait_t(19); chk("pwr_nop", 24'(cmd4), 24'(4'b0111));
      wait_t(20); chk("pre_all", 24'({cmd4, addr}), 24'({4'b0010, 13'h0400}));
      wait_t(22); chk("aref1", 24'(cmd4), 24'(4'b0001));
      wait_t(29); chk("aref2", 24'(cmd4), 24'(4'b0001));
      wait_t(36); chk("lmr", 24'({cmd4, addr}), 24'({4'b0000, 13'h033}));
      wait_t(37); chk("init_pending", 24'(init_done), 24'(0));
      wait_t(38); chk("init_done", 24'({init_done, cmd_own}), 24'(2'b10));

      // periodic refresh with grant tied high
      wait_t(88);  chk("req_rise", 24'(ref_req), 24'(1));
      wait_t(89);  chk("ref_aref", 24'({cmd_own, cmd4}), 24'(5'b10001));
      wait_t(95);  chk("ref_done", 24'(ref_done), 24'(1));
      wait_t(96);  chk("ref_release", 24'({cmd_own, ref_done, ref_req}), 24'(0));
      wait_t(139); chk("ref_aref2", 24'(cmd4), 24'(4'b0001));

      // expiry coincident with AUTO_REF issue
      wait_t(140); gnt = 1'b0;
      wait_t(236); gnt = 1'b1;
      wait_t(237); chk("coinc_aref", 24'(cmd4), 24'(4'b0001));
      wait_t(238); chk("coinc_req", 24'({ref_req, ref_overrun}), 24'(2'b10));
      wait_t(245); chk("coinc_next", 24'(cmd4), 24'(4'b0001));
      wait_t(246); chk("coinc_drop", 24'(ref_req), 24'(0));

      // grant withheld over several intervals
      wait_t(250); gnt = 1'b0;
`ifdef SDR_REF_POSTPONE_EN
      wait_t(488); chk("debt5", 24'({ref_req, ref_overrun}), 24'(2'b10));
      wait_t(490); gnt = 1'b1;
      wait_t(491); chk("burst_first", 24'(cmd4), 24'(4'b0001));
      wait_t(523); chk("burst_fifth", 24'(cmd4), 24'(4'b0001));
      wait_t(524); chk("burst_done", 24'({ref_req, ref_overrun}), 24'(0));
      wait_t(530); gnt = 1'b0;
      wait_t(937); chk("debt8_no_ovr", 24'(ref_overrun), 24'(0));
      wait_t(938); chk("debt_ovr", 24'({ref_req, ref_overrun}), 24'(2'b11));
`else
      wait_t(337); chk("no_ovr_yet", 24'(ref_overrun), 24'(0));
      wait_t(338); chk("flag_ovr", 24'({ref_req, ref_overrun}), 24'(2'b11));
      wait_t(490); gnt = 1'b1;
      wait_t(491); chk("late_aref", 24'(cmd4), 24'(4'b0001));
      wait_t(492); chk("late_drop", 24'({ref_req, ref_overrun}), 24'(2'b01));
`endif

      // reset during runtime S_REF_WAIT
      @(posedge clk); #2 async_reset("async_rst_clr");
      gnt = 1'b1;
      release_rst();
      wait_t(20); chk("pre_again", 24'(cmd4), 24'(4'b0010));
      wait_t(91); async_reset("async_rst_refwait");
      release_rst();
      wait_t(40); chk("reinit_done", 24'({init_done, cmd_own, ref_overrun}), 24'(3'b100));

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
